prog_fetch: RTL and testbench

PROG_FETCH -- requirements
Module: prog_fetch

---
 rtl/prog_fetch.sv | 139 +++++++++++++
 tb/tb_prog_fetch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_fetch.sv
// prog_fetch: fetches a 32-bit instruction as two 16-bit ROM half-words
// (upper half first) with wait-state handshake, timeout and flush.
// Ports: clk, rst (async active-low), fetch_req/fetch_addr/flush (request
//   side), ins_out/ins_valid/busy/fetch_err (result side),
//   mem_addr/mem_rd/mem_data/mem_ready (ROM side).
// Macro PROG_FETCH_CACHE_EN adds a one-entry instruction cache.
module prog_fetch #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [13:0] fetch_addr,
    input  logic        flush,
    output logic [31:0] ins_out,
    output logic        ins_valid,
    output logic        busy,
    output logic        fetch_err,
    output logic [14:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, DONE} state_t;

    // The abort fires on the edge that would bring the count to TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [13:0] addr_q;
    logic [31:0] ins_q;
    logic        valid_q;
    logic        err_q;
    logic        rd_q;
    logic [14:0] maddr_q;
    logic [7:0]  wait_q;

`ifdef PROG_FETCH_CACHE_EN
    logic [13:0] tag_q;
    logic [31:0] cdata_q;
    logic        cvalid_q;
    logic        hit_d;

    assign hit_d = cvalid_q && (tag_q == fetch_addr);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            ins_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
            maddr_q  <= '0;
            wait_q   <= '0;
`ifdef PROG_FETCH_CACHE_EN
            tag_q    <= '0;
            cdata_q  <= '0;
            cvalid_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (fetch_req && !flush) begin
                        addr_q <= fetch_addr;
                        wait_q <= '0;
`ifdef PROG_FETCH_CACHE_EN
                        if (hit_d) begin
                            ins_q   <= cdata_q;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            maddr_q <= {fetch_addr, 1'b0};
                            rd_q    <= 1'b1;
                            state_q <= RD_HI;
                        end
`else
                        maddr_q <= {fetch_addr, 1'b0};
                        rd_q    <= 1'b1;
                        state_q <= RD_HI;
`endif
                    end
                end
                RD_HI, RD_LO: begin
                    if (flush) begin
                        rd_q    <= 1'b0;
                        wait_q  <= '0;
                        state_q <= IDLE;
                    end else if (mem_ready) begin
                        wait_q <= '0;
                        if (state_q == RD_HI) begin
                            ins_q[31:16] <= mem_data;
                            maddr_q      <= {addr_q, 1'b1};
                            state_q      <= RD_LO;
                        end else begin
                            ins_q[15:0] <= mem_data;
                            rd_q        <= 1'b0;
                            valid_q     <= 1'b1;
                            state_q     <= DONE;
`ifdef PROG_FETCH_CACHE_EN
                            tag_q    <= addr_q;
                            cdata_q  <= {ins_q[31:16], mem_data};
                            cvalid_q <= 1'b1;
`endif
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        ins_q   <= '0;
                        valid_q <= 1'b1;
                        err_q   <= 1'b1;
                        rd_q    <= 1'b0;
                        wait_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A flush during the DONE cycle withdraws the pending result.
    assign ins_valid = valid_q & ~(flush & (state_q == DONE));
    assign ins_out   = ins_q;
    assign busy      = (state_q != IDLE);
    assign fetch_err = err_q;
    assign mem_addr  = maddr_q;
    assign mem_rd    = rd_q;

endmodule

// File: tb/tb_prog_fetch.sv
// tb_prog_fetch: self-checking bench for prog_fetch.
// Table vectors, hand sequences and random fetches against a ROM model.
module tb_prog_fetch;

    localparam int TMO = 15;

    typedef bit rdy_t[64];

    typedef struct {
        logic [13:0] addr;
        int          wh;
        int          wl;
        logic [31:0] ins;
        int          lat;
        bit          err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [13:0] fetch_addr;
    logic        flush;
    logic [31:0] ins_out;
    logic        ins_valid;
    logic        busy;
    logic        fetch_err;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;

    int errors = 0;
    int checks = 0;

    bit          cv = 0;
    logic [13:0] ctag = '0;

    prog_fetch #(.TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .flush(flush),
        .ins_out(ins_out),
        .ins_valid(ins_valid),
        .busy(busy),
        .fetch_err(fetch_err),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] romv(input logic [14:0] a);
        if (a == 15'd0) return 16'h1234;
        if (a == 15'd1) return 16'h5678;
        return {a[7:0], ~a[14:7]} ^ 16'h3C5A;
    endfunction

    function automatic logic [31:0] insv(input logic [13:0] a);
        return {romv({a, 1'b0}), romv({a, 1'b1})};
    endfunction

    assign mem_data = romv(mem_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outcome of one fetch from its ready pattern: cycle (after the request
    // edge) at which the result shows, and whether it is a timeout.
    task automatic predict(input rdy_t r, output int lat, output bit err);
        int half;
        int w;
        half = 0;
        w = 0;
        lat = -1;
        err = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (r[i]) begin
                if (half == 0) begin
                    half = 1;
                    w = 0;
                end else begin
                    lat = i + 2;
                    return;
                end
            end else begin
                w++;
                if (w == TMO) begin
                    lat = i + 2;
                    err = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic run_fetch(input string nm, input logic [13:0] a,
                             input rdy_t r, input int lat_in,
                             input bit err_in, input logic [31:0] ins_in);
        int          lat;
        bit          err;
        logic [31:0] ins;
        logic        h;
        bit          done;
        lat = lat_in;
        err = err_in;
        ins = ins_in;
        h = 1'b0;
        done = 1'b0;
`ifdef PROG_FETCH_CACHE_EN
        if (cv && ctag == a) begin
            lat = 1;
            err = 1'b0;
            ins = insv(a);
        end
`endif
        fetch_req = 1'b1;
        fetch_addr = a;
        step();
        for (int k = 1; k < 64; k++) begin
            if (ins_valid) begin
                chk({nm, ".lat"}, 32'(k), 32'(lat));
                chk({nm, ".err"}, 32'(fetch_err), 32'(err));
                chk({nm, ".ins"}, ins_out, err ? 32'h0 : ins);
                chk({nm, ".rd_end"}, 32'(mem_rd), 32'd0);
                if (!err && lat > 1)
                    chk({nm, ".addr_hold"}, 32'(mem_addr), 32'({a, 1'b1}));
                done = 1'b1;
                break;
            end
            chk({nm, ".busy"}, 32'(busy), 32'd1);
            chk({nm, ".rd"}, 32'(mem_rd), 32'd1);
            chk({nm, ".addr"}, 32'(mem_addr), 32'({a, h}));
            mem_ready = r[k-1];
            if (r[k-1]) h = 1'b1;
            // requests while busy must be ignored
            fetch_req = 1'b1;
            fetch_addr = a ^ 14'h155;
            step();
        end
        fetch_req = 1'b0;
        mem_ready = 1'b1;
        if (!done) chk({nm, ".no_valid"}, 32'd0, 32'd1);
        step();
        chk({nm, ".pulse"}, 32'(ins_valid), 32'd0);
        chk({nm, ".idle"}, 32'(busy), 32'd0);
        chk({nm, ".err_off"}, 32'(fetch_err), 32'd0);
        if (done && !err) begin
            cv = 1'b1;
            ctag = a;
        end
    endtask

    function automatic rdy_t mk_rdy(input int wh, input int wl);
        rdy_t r;
        for (int i = 0; i < 64; i++) r[i] = 1'b1;
        for (int i = 0; i < wh && i < 64; i++) r[i] = 1'b0;
        for (int i = 0; i < wl && wh + 1 + i < 64; i++) r[wh+1+i] = 1'b0;
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got stuck expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[7];
        rdy_t        r;
        int          lat;
        bit          err;
        logic [13:0] a;

        tbl[0] = '{14'h0000, 0, 0, 32'h12345678, 3, 1'b0};
        tbl[1] = '{14'h3FFF, 2, 2, insv(14'h3FFF), 7, 1'b0};
        tbl[2] = '{14'h0005, 1, 0, insv(14'h0005), 4, 1'b0};
        tbl[3] = '{14'h0100, 0, 14, insv(14'h0100), 17, 1'b0};
        tbl[4] = '{14'h0007, 15, 0, 32'h0, 16, 1'b1};
        tbl[5] = '{14'h0009, 0, 15, 32'h0, 17, 1'b1};
        tbl[6] = '{14'h2ABC, 14, 14, insv(14'h2ABC), 31, 1'b0};

        rst = 1'b0;
        fetch_req = 1'b0;
        fetch_addr = '0;
        flush = 1'b0;
        mem_ready = 1'b1;
        repeat (3) step();
        chk("rst.ins", ins_out, 32'h0);
        chk("rst.valid", 32'(ins_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.err", 32'(fetch_err), 32'd0);
        chk("rst.rd", 32'(mem_rd), 32'd0);
        chk("rst.addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;

        // first vector is issued on the first edge after release
        for (int i = 0; i < 7; i++) begin
            run_fetch($sformatf("vec%0d", i), tbl[i].addr,
                      mk_rdy(tbl[i].wh, tbl[i].wl),
                      tbl[i].lat, tbl[i].err, tbl[i].ins);
        end

        for (int n = 0; n < 40; n++) begin
            a = 14'($urandom);
            for (int i = 0; i < 64; i++)
                r[i] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                int s;
                s = $urandom_range(0, 3);
                for (int i = 0; i < TMO; i++) r[s+i] = 1'b0;
            end
            predict(r, lat, err);
            run_fetch($sformatf("rnd%0d", n), a, r, lat, err, insv(a));
        end

        // flush in RD_LO
        fetch_req = 1'b1;
        fetch_addr = 14'd20;
        step();
        fetch_req = 1'b0;
        step();
        chk("flush.rd_lo_addr", 32'(mem_addr), 32'({14'd20, 1'b1}));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush.busy", 32'(busy), 32'd0);
        chk("flush.valid", 32'(ins_valid), 32'd0);
        chk("flush.rd", 32'(mem_rd), 32'd0);
        step();
        chk("flush.valid2", 32'(ins_valid), 32'd0);
        chk("flush.err2", 32'(fetch_err), 32'd0);
        run_fetch("after_flush", 14'd30, mk_rdy(0, 0), 3, 1'b0, insv(14'd30));

        // flush beats a simultaneous request in IDLE
        flush = 1'b1;
        fetch_req = 1'b1;
        fetch_addr = 14'd40;
        step();
        flush = 1'b0;
        fetch_req = 1'b0;
        chk("flushreq.busy", 32'(busy), 32'd0);
        chk("flushreq.rd", 32'(mem_rd), 32'd0);
        step();
        chk("flushreq.valid", 32'(ins_valid), 32'd0);

        // asynchronous reset in RD_HI
        fetch_req = 1'b1;
        fetch_addr = 14'd50;
        step();
        fetch_req = 1'b0;
        mem_ready = 1'b0;
        chk("mrst.busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.rd", 32'(mem_rd), 32'd0);
        chk("mrst.addr", 32'(mem_addr), 32'd0);
        chk("mrst.ins", ins_out, 32'h0);
        chk("mrst.valid", 32'(ins_valid), 32'd0);
        chk("mrst.err", 32'(fetch_err), 32'd0);
        step();
        rst = 1'b1;
        mem_ready = 1'b1;
        cv = 1'b0;
        run_fetch("after_rst", 14'd50, mk_rdy(0, 0), 3, 1'b0, insv(14'd50));

`ifdef PROG_FETCH_CACHE_EN
        run_fetch("c5a", 14'd5, mk_rdy(0, 0), 3, 1'b0, insv(14'd5));
        run_fetch("c5hit", 14'd5, mk_rdy(0, 0), 1, 1'b0, insv(14'd5));
        run_fetch("c6", 14'd6, mk_rdy(0, 0), 3, 1'b0, insv(14'd6));
        chk("c6.tag", 32'(ctag), 32'd6);
        run_fetch("c5b", 14'd5, mk_rdy(0, 0), 3, 1'b0, insv(14'd5));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
